// File: rtl/move_queue_ctrl.sv
// move_queue_ctrl: producer side of the DDA move buffer ring.
// Writes accepted moves into free slots, arms them by toggling the slot's
// stepready bit, retires slots on move_done toggles, and exposes the slot the
// sequencer is currently indexing. Handles abort/drain and sticky faults.
module move_queue_ctrl #(
    parameter int buffer_bits        = 2,
    parameter int buffer_size        = 4,
    parameter int move_duration_bits = 32,
    parameter int payload_bits       = 64
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [move_duration_bits-1:0] cmd_duration,
    input  logic [payload_bits-1:0]       cmd_payload,
    input  logic                          abort,
    input  logic                          run,
    input  logic                          clear_fault,
    input  logic [buffer_bits-1:0]        moveind,
    input  logic                          move_done,
    output logic [buffer_size-1:0]        stepready,
    output logic [move_duration_bits-1:0] move_duration,
    output logic [payload_bits-1:0]       move_payload,
    output logic [buffer_bits:0]          count,
    output logic                          empty,
    output logic                          full,
    output logic                          abort_done,
    output logic                          underrun,
    output logic                          seq_error
);

    localparam logic [buffer_bits:0]   CNT_MAX_C  = (buffer_bits+1)'(buffer_size);
    localparam logic [buffer_bits:0]   CNT_ONE_C  = (buffer_bits+1)'(1);
    localparam logic [buffer_bits:0]   CNT_ZERO_C = (buffer_bits+1)'(0);
    localparam logic [buffer_bits-1:0] PTR_ONE_C  = (buffer_bits)'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10
    } state_e;

    state_e                  state_q, state_d;
    logic [buffer_bits-1:0]  wr_ptr_q, wr_ptr_d;
    logic [buffer_bits-1:0]  rd_ptr_q, rd_ptr_d;
    logic [buffer_bits:0]    count_q, count_d;
    logic [buffer_size-1:0]  stepready_q, stepready_d;
    logic                    move_done_q;
    logic                    underrun_q, underrun_d;
    logic                    seq_error_q, seq_error_d;

    // Slot storage is deliberately left unreset.
    logic [move_duration_bits-1:0] dur_mem [buffer_size];
    logic [payload_bits-1:0]       pay_mem [buffer_size];

    logic cmd_ready_s;
    logic accept_s;
    logic compl_s;
    logic abort_done_s;
    logic seq_set_s;
    logic under_set_s;
    logic [buffer_bits-1:0] rd_next_s;

    // Handshake, completion edge and fault-set conditions.
    always_comb begin
        cmd_ready_s  = resetn & ~abort & (state_q != ST_DRAIN) & (count_q < CNT_MAX_C);
        accept_s     = cmd_valid & cmd_ready_s;
        compl_s      = move_done ^ move_done_q;
        rd_next_s    = rd_ptr_q + PTR_ONE_C;
        abort_done_s = resetn & (state_q == ST_DRAIN) & (count_q == CNT_ZERO_C);
        // A completion with nothing queued, or out of ring order, is a sequencing fault.
        seq_set_s    = compl_s & ((moveind != rd_next_s) | (count_q == CNT_ZERO_C));
        under_set_s  = compl_s & ~accept_s & run & (count_q == CNT_ONE_C);
    end

    // Next-state for pointers, occupancy, arm toggles and sticky flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        stepready_d = stepready_q;
        if (accept_s) begin
            wr_ptr_d              = wr_ptr_q + PTR_ONE_C;
            stepready_d[wr_ptr_q] = ~stepready_q[wr_ptr_q];
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (compl_s) begin
            rd_ptr_d = rd_next_s;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({accept_s, compl_s})
            2'b10: count_d = count_q + CNT_ONE_C;
            2'b01: begin
                // Saturate at zero on a spurious completion.
                if (count_q == CNT_ZERO_C) begin
                    count_d = count_q;
                end else begin
                    count_d = count_q - CNT_ONE_C;
                end
            end
            default: count_d = count_q;
        endcase
        // Set events override a simultaneous clear.
        underrun_d  = under_set_s | (underrun_q & ~clear_fault);
        seq_error_d = seq_set_s | (seq_error_q & ~clear_fault);
    end

    // Queue state machine next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (abort) begin
                    state_d = ST_DRAIN;
                end else if (accept_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_DRAIN;
                end else if (count_d == CNT_ZERO_C) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (count_q == CNT_ZERO_C) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            stepready_q <= '0;
            move_done_q <= 1'b0;
            underrun_q  <= 1'b0;
            seq_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            stepready_q <= stepready_d;
            move_done_q <= move_done;
            underrun_q  <= underrun_d;
            seq_error_q <= seq_error_d;
        end
    end

    // Slot write on accept; only free slots are ever accepted.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            dur_mem[wr_ptr_q] <= cmd_duration;
            pay_mem[wr_ptr_q] <= cmd_payload;
        end
    end

    assign cmd_ready     = cmd_ready_s;
    assign stepready     = stepready_q;
    assign move_duration = dur_mem[moveind];
    assign move_payload  = pay_mem[moveind];
    assign count         = count_q;
    assign empty         = (count_q == CNT_ZERO_C);
    assign full          = (count_q == CNT_MAX_C);
    assign abort_done    = abort_done_s;
    assign underrun      = underrun_q;
    assign seq_error     = seq_error_q;

endmodule

// File: tb/tb_move_queue_ctrl.sv
// Directed, table-driven bench for move_queue_ctrl. Each row gives the inputs
// driven for one cycle and the outputs expected in that cycle, before the edge.
module tb_move_queue_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_duration;
    logic [63:0] cmd_payload;
    logic        abort;
    logic        run;
    logic        clear_fault;
    logic [1:0]  moveind;
    logic        move_done;
    logic [3:0]  stepready;
    logic [31:0] move_duration;
    logic [63:0] move_payload;
    logic [2:0]  count;
    logic        empty;
    logic        full;
    logic        abort_done;
    logic        underrun;
    logic        seq_error;

    int n_checks = 0;
    int n_fail   = 0;

    move_queue_ctrl dut (
        .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_duration(cmd_duration), .cmd_payload(cmd_payload), .abort(abort),
        .run(run), .clear_fault(clear_fault), .moveind(moveind), .move_done(move_done),
        .stepready(stepready), .move_duration(move_duration), .move_payload(move_payload),
        .count(count), .empty(empty), .full(full), .abort_done(abort_done),
        .underrun(underrun), .seq_error(seq_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [31:0] dur;
        logic        ab;
        logic        run;
        logic        clr;
        logic [1:0]  mi;
        logic        md;
        logic        rdy;
        logic [2:0]  cnt;
        logic [3:0]  sr;
        logic        cd;
        logic [31:0] edur;
        logic        ad;
        logic        ur;
        logic        se;
    } vec_t;

    localparam int NV = 36;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic v, input int dur, input logic ab, input logic rn,
                                input logic clr, input int mi, input logic md, input logic rdy,
                                input int cnt, input logic [3:0] sr, input logic cd, input int edur,
                                input logic ad, input logic ur, input logic se);
        vec_t r;
        r.v = v; r.dur = 32'(dur); r.ab = ab; r.run = rn; r.clr = clr; r.mi = 2'(mi);
        r.md = md; r.rdy = rdy; r.cnt = 3'(cnt); r.sr = sr; r.cd = cd; r.edur = 32'(edur);
        r.ad = ad; r.ur = ur; r.se = se;
        return r;
    endfunction

    function automatic logic [63:0] pay_of(input logic [31:0] d);
        return {~d, d};
    endfunction

    task automatic check(input string name, input int row, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] dur);
        cmd_duration = dur;
        cmd_payload  = pay_of(dur);
    endtask

    initial begin
        //          v  dur ab rn cl mi md | rdy cnt sr     cd edur ad ur se
        tbl[0]  = mk(1, 10, 0, 0, 0, 0, 0,   1, 0, 4'b0000, 0,  0, 0, 0, 0);
        tbl[1]  = mk(1, 20, 0, 0, 0, 0, 0,   1, 1, 4'b0001, 1, 10, 0, 0, 0);
        tbl[2]  = mk(1, 30, 0, 0, 0, 0, 0,   1, 2, 4'b0011, 1, 10, 0, 0, 0);
        tbl[3]  = mk(1, 40, 0, 0, 0, 0, 0,   1, 3, 4'b0111, 1, 10, 0, 0, 0);
        tbl[4]  = mk(1, 50, 0, 0, 0, 0, 0,   0, 4, 4'b1111, 1, 10, 0, 0, 0);
        tbl[5]  = mk(0,  0, 0, 0, 0, 1, 1,   0, 4, 4'b1111, 1, 20, 0, 0, 0);
        tbl[6]  = mk(0,  0, 0, 0, 0, 1, 1,   1, 3, 4'b1111, 1, 20, 0, 0, 0);
        tbl[7]  = mk(0,  0, 0, 0, 0, 2, 0,   1, 3, 4'b1111, 1, 30, 0, 0, 0);
        tbl[8]  = mk(1, 60, 0, 0, 0, 3, 1,   1, 2, 4'b1111, 1, 40, 0, 0, 0);
        tbl[9]  = mk(0,  0, 0, 0, 0, 0, 1,   1, 2, 4'b1110, 1, 60, 0, 0, 0);
        tbl[10] = mk(0,  0, 0, 0, 0, 0, 0,   1, 2, 4'b1110, 1, 60, 0, 0, 0);
        tbl[11] = mk(0,  0, 0, 0, 0, 1, 1,   1, 1, 4'b1110, 1, 20, 0, 0, 0);
        tbl[12] = mk(1, 70, 0, 0, 0, 1, 1,   1, 0, 4'b1110, 1, 20, 0, 0, 0);
        tbl[13] = mk(1, 80, 0, 0, 0, 1, 1,   1, 1, 4'b1100, 1, 70, 0, 0, 0);
        tbl[14] = mk(1, 90, 0, 0, 0, 1, 1,   1, 2, 4'b1000, 1, 70, 0, 0, 0);
        tbl[15] = mk(1,100, 1, 0, 0, 1, 1,   0, 3, 4'b0000, 1, 70, 0, 0, 0);
        tbl[16] = mk(1,  0, 0, 0, 0, 2, 0,   0, 3, 4'b0000, 1, 80, 0, 0, 0);
        tbl[17] = mk(1,  0, 0, 0, 0, 3, 1,   0, 2, 4'b0000, 1, 90, 0, 0, 0);
        tbl[18] = mk(1,  0, 0, 0, 0, 0, 0,   0, 1, 4'b0000, 1, 60, 0, 0, 0);
        tbl[19] = mk(1,110, 0, 0, 0, 0, 0,   0, 0, 4'b0000, 1, 60, 1, 0, 0);
        tbl[20] = mk(0,  0, 0, 0, 0, 0, 0,   1, 0, 4'b0000, 1, 60, 0, 0, 0);
        tbl[21] = mk(1,120, 0, 1, 0, 0, 0,   1, 0, 4'b0000, 1, 60, 0, 0, 0);
        tbl[22] = mk(0,  0, 0, 1, 0, 1, 1,   1, 1, 4'b0001, 1, 70, 0, 0, 0);
        tbl[23] = mk(0,  0, 0, 1, 0, 1, 1,   1, 0, 4'b0001, 1, 70, 0, 1, 0);
        tbl[24] = mk(0,  0, 0, 0, 0, 3, 0,   1, 0, 4'b0001, 1, 90, 0, 1, 0);
        tbl[25] = mk(0,  0, 0, 0, 0, 3, 0,   1, 0, 4'b0001, 1, 90, 0, 1, 1);
        tbl[26] = mk(0,  0, 0, 0, 1, 0, 1,   1, 0, 4'b0001, 1,120, 0, 1, 1);
        tbl[27] = mk(0,  0, 0, 0, 0, 0, 1,   1, 0, 4'b0001, 1,120, 0, 0, 1);
        tbl[28] = mk(0,  0, 0, 0, 1, 0, 1,   1, 0, 4'b0001, 1,120, 0, 0, 1);
        tbl[29] = mk(0,  0, 0, 0, 0, 0, 1,   1, 0, 4'b0001, 1,120, 0, 0, 0);
        tbl[30] = mk(0,  0, 1, 0, 0, 0, 1,   0, 0, 4'b0001, 1,120, 0, 0, 0);
        tbl[31] = mk(0,  0, 0, 0, 0, 0, 1,   0, 0, 4'b0001, 1,120, 1, 0, 0);
        tbl[32] = mk(0,  0, 0, 0, 0, 0, 1,   1, 0, 4'b0001, 1,120, 0, 0, 0);
        tbl[33] = mk(1,130, 0, 0, 0, 0, 1,   1, 0, 4'b0001, 1,120, 0, 0, 0);
        tbl[34] = mk(0,  0, 0, 0, 0, 2, 0,   1, 1, 4'b0011, 1, 80, 0, 0, 0);
        tbl[35] = mk(0,  0, 0, 0, 0, 2, 0,   1, 0, 4'b0011, 1, 80, 0, 0, 1);

        // Reset with a command offered: nothing may be accepted.
        resetn = 1'b0; cmd_valid = 1'b1; drive(32'd999); abort = 1'b0; run = 1'b0;
        clear_fault = 1'b0; moveind = 2'd0; move_done = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rst_ready", -1, 64'(cmd_ready), 64'd0);
        check("rst_abort_done", -1, 64'(abort_done), 64'd0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            resetn      = 1'b1;
            cmd_valid   = tbl[i].v;
            drive(tbl[i].dur);
            abort       = tbl[i].ab;
            run         = tbl[i].run;
            clear_fault = tbl[i].clr;
            moveind     = tbl[i].mi;
            move_done   = tbl[i].md;
            #1;
            check("cmd_ready", i, 64'(cmd_ready), 64'(tbl[i].rdy));
            check("count", i, 64'(count), 64'(tbl[i].cnt));
            check("full", i, 64'(full), 64'(tbl[i].cnt == 3'd4));
            check("empty", i, 64'(empty), 64'(tbl[i].cnt == 3'd0));
            check("stepready", i, 64'(stepready), 64'(tbl[i].sr));
            check("abort_done", i, 64'(abort_done), 64'(tbl[i].ad));
            check("underrun", i, 64'(underrun), 64'(tbl[i].ur));
            check("seq_error", i, 64'(seq_error), 64'(tbl[i].se));
            if (tbl[i].cd) begin
                check("move_duration", i, 64'(move_duration), 64'(tbl[i].edur));
                check("move_payload", i, move_payload, pay_of(tbl[i].edur));
            end
        end

        // Mid-stream reset: flags, arms and occupancy all return to zero.
        @(negedge clk);
        resetn = 1'b0; cmd_valid = 1'b0; abort = 1'b0; clear_fault = 1'b0;
        @(negedge clk); #1;
        check("rst2_count", 100, 64'(count), 64'd0);
        check("rst2_stepready", 100, 64'(stepready), 64'd0);
        check("rst2_seq_error", 100, 64'(seq_error), 64'd0);
        check("rst2_empty", 100, 64'(empty), 64'd1);
        check("rst2_ready", 100, 64'(cmd_ready), 64'd0);
        @(negedge clk);
        resetn = 1'b1; #1;
        check("rst2_ready_after", 101, 64'(cmd_ready), 64'd1);
        // move_done is still 0 after reset, so no completion may be seen.
        @(negedge clk); #1;
        check("rst2_no_compl", 102, 64'(seq_error), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
